serial_collector: RTL

// - Receive end of the LSB-first serial link driven by the output emitter.
// - Samples serial_in on each fast_clk edge while serial_en is high and assembles DATA_WIDTH bits into a parallel word.
// - Presents the word on a valid/ready interface to the downstream consumer.
// - Double-buffered: the next frame can be collected while the previous word is still held.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_collector_if.sv | 27 ++
 rtl/serial_shift_in.sv | 28 ++
 rtl/serial_collector.sv | 129 ++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (collector and emitter sides):
// FSM state encoding, default frame width and bit-counter width.
package serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHIFT    = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_t;

   localparam int unsigned DATA_WIDTH_DEF = 16;

   // Counter must hold the value DATA_WIDTH itself, hence the extra bit.
   function automatic int unsigned cnt_width(input int unsigned dw);
      return $clog2(dw) + 1;
   endfunction

   localparam int unsigned CNT_W_DEF = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/serial_collector_if.sv
// Serial input and valid/ready output bundle of the serial collector.
// slave: the collector itself; master: the link driver / downstream consumer.
interface serial_collector_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  serial_in;
   logic                  serial_en;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;

   modport slave (
      input  serial_in,
      input  serial_en,
      input  out_ready,
      output out_data,
      output out_valid
   );

   modport master (
      output serial_in,
      output serial_en,
      output out_ready,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/serial_shift_in.sv
// Indexed bit-capture register: writes one bit at position wr_idx per
// enabled cycle; synchronous clear has priority.
module serial_shift_in #(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned IDX_W = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_bit,
   output logic [WIDTH-1:0] q
);

   // Capture the incoming bit into the addressed position.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               q[i] <= wr_bit;
            end
         end
      end
   end

endmodule

// File: rtl/serial_collector.sv
// Serial collector: assembles LSB-first frames of DATA_WIDTH bits from
// serial_in/serial_en and presents them on a valid/ready output.
// Optional feature: define SERIAL_OVERRUN_EN to add the sticky overrun port.
module serial_collector
   import serial_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic              fast_clk,
   input  logic              reset,
   serial_collector_if.slave bus,
   output logic              busy,
   output logic              frame_err
`ifdef SERIAL_OVERRUN_EN
   ,
   output logic              overrun
`endif
);

   localparam int unsigned        CNT_W    = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cap_idx;
   logic                  cap_wr;
   logic                  word_done;
   logic                  abort;
   logic [DATA_WIDTH-2:0] cap_q;

   // The final bit goes straight into out_data, so the capture register only
   // needs to hold bits 0..DATA_WIDTH-2.
   serial_shift_in #(
      .WIDTH (DATA_WIDTH - 1),
      .IDX_W (CNT_W)
   ) u_shift_in (
      .clk    (fast_clk),
      .clr    (~reset),
      .wr_en  (cap_wr),
      .wr_idx (cap_idx),
      .wr_bit (bus.serial_in),
      .q      (cap_q)
   );

   // FSM state register.
   always_ff @(posedge fast_clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      state_nxt = state;
      cap_wr    = 1'b0;
      word_done = 1'b0;
      abort     = 1'b0;
      cap_idx   = '0;
      case (state)
         ST_IDLE: begin
            if (bus.serial_en) begin
               cap_wr    = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (bus.serial_en) begin
               if (cnt == LAST_IDX) begin
                  word_done = 1'b1;
                  state_nxt = ST_WAIT_LOW;
               end else begin
                  cap_wr  = 1'b1;
                  cap_idx = cnt;
               end
            end else begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_LOW: begin
            if (!bus.serial_en) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bit counter: 1 after bit 0, incremented for each bit taken in SHIFT.
   always_ff @(posedge fast_clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (bus.serial_en) begin
         if (state == ST_IDLE)       cnt <= CNT_W'(1);
         else if (state == ST_SHIFT) cnt <= cnt + CNT_W'(1);
      end
   end

   // Output word buffer and valid/ready handshake.
   always_ff @(posedge fast_clk) begin
      if (!reset) begin
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else if (word_done) begin
         bus.out_data  <= {bus.serial_in, cap_q};
         bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // One-cycle pulse when a frame is cut short.
   always_ff @(posedge fast_clk) begin
      if (!reset) frame_err <= 1'b0;
      else        frame_err <= abort;
   end

`ifdef SERIAL_OVERRUN_EN
   // Sticky flag: a word completed over one the consumer had not taken.
   always_ff @(posedge fast_clk) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (word_done && bus.out_valid && !bus.out_ready) begin
         overrun <= 1'b1;
      end
   end
`endif

   assign busy = (state != ST_IDLE);

endmodule
